// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared picorv32 RAM port.
// It grants one transaction at a time and answers a stalled RAM with a bus-error response.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_err,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_err,
  output logic                  s_valid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_ready,
  output logic                  owner,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT);
  localparam logic        TMO_ENABLE = (TIMEOUT != 0);
  localparam logic [31:0] ERR_RDATA  = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

  arbState_t r_state;
  arbState_t w_nextState;

  logic        r_owner;
  logic        r_lastOwner;
  logic [15:0] r_tmoCnt;
  logic [7:0]  r_errCount;

  logic                  w_ownerValid;
  logic [ADDR_WIDTH-1:0] w_ownerAddr;
  logic [31:0]           w_ownerWdata;
  logic [3:0]            w_ownerWstrb;
  logic                  w_grant;
  logic                  w_winner;
  logic                  w_abort;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_ready;
  logic [31:0]           w_rdata;

  assign w_ownerValid = r_owner ? m1_valid : m0_valid;
  assign w_ownerAddr  = r_owner ? m1_addr  : m0_addr;
  assign w_ownerWdata = r_owner ? m1_wdata : m0_wdata;
  assign w_ownerWstrb = r_owner ? m1_wstrb : m0_wstrb;

  // On contention the master that did not finish the previous transaction wins.
  assign w_grant  = (r_state == IDLE) && (m0_valid || m1_valid);
  assign w_winner = (m0_valid && m1_valid) ? ~r_lastOwner : m1_valid;

  // s_ready beats the timeout, and a withdrawn request beats both.
  assign w_abort    = (r_state == BUSY) && !w_ownerValid;
  assign w_complete = (r_state == BUSY) && w_ownerValid && s_ready;
  assign w_timeout  = (r_state == BUSY) && w_ownerValid && !s_ready &&
                      TMO_ENABLE && (r_tmoCnt == TMO_LIMIT);

  assign w_ready = w_complete || w_timeout;
  assign w_rdata = w_timeout ? ERR_RDATA : s_rdata;

  assign owner     = r_owner;
  assign busy      = (r_state == BUSY);
  assign err_count = r_errCount;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_abort || w_complete || w_timeout) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner     <= 1'b0;
      r_lastOwner <= 1'b1;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
      end
      if (w_complete || w_timeout) begin
        r_lastOwner <= r_owner;
      end
    end
  end

  // The counter saturates so that a disabled timeout never wraps into a false match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmoCnt <= 16'd0;
    end else if (w_grant) begin
      r_tmoCnt <= 16'd0;
    end else if ((r_state == BUSY) && !(w_abort || w_complete || w_timeout) &&
                 (r_tmoCnt != 16'hFFFF)) begin
      r_tmoCnt <= r_tmoCnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_errCount <= 8'd0;
    end else if (w_timeout && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = 32'd0;
    s_wstrb  = 4'd0;
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = 32'd0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = 32'd0;
    if (r_state == BUSY) begin
      s_valid = w_ownerValid && !w_timeout;
      s_addr  = w_ownerAddr;
      s_wdata = w_ownerWdata;
      s_wstrb = w_ownerWstrb;
      if (r_owner) begin
        m1_ready = w_ready;
        m1_err   = w_timeout;
        m1_rdata = w_rdata;
      end else begin
        m0_ready = w_ready;
        m0_err   = w_timeout;
        m0_rdata = w_rdata;
      end
    end
  end

endmodule
